mmap_protocol_engine: RTL and testbench
=======================================

// Module: mmap_protocol_engine
// PURPOSE
//  Byte-stream to memory-map bridge: parses host commands arriving as UART
//  bytes into memory-mapped read/write requests, and streams read data back
//  as bytes. Sits between the UART rx/tx byte interface and the register/
//  memory fabric (master side m_*, slave response s_*).
// PARAMETERS
//  none (all widths fixed: 8-bit bytes, 6-bit cmd, 16-bit count, 32-bit addr/data)
// PORTS
//  clk          in   1   system clock; single clock domain
//  rst          in   1   asynchronous, active-high reset
//  rx_data      in   8   received byte
//  new_rx_data  in   1   rx_data valid; every cycle high consumes one byte
//  tx_data      out  8   byte to transmit
//  new_tx_data  out  1   1-cycle strobe: tx_data valid
//  tx_busy      in   1   transmitter busy; no strobe while high
//  m_new_cmd    out  1   1-cycle strobe: request valid on m_*
//  m_write      out  1   1=write, 0=read
//  m_cmd        out  6   command code from header byte
//  m_address    out  32  word address of current transfer
//  m_data       out  32  write data (valid with m_new_cmd when m_write=1)
//  s_data       in   32  read data from slave
//  s_drdy       in   1   1-cycle strobe: s_data valid for outstanding read
// BEHAVIOUR
//  Reset: all outputs 0; FSM to IDLE; internal count/shift regs cleared.
//  Packet (all multi-byte fields big-endian, MSB first):
//   hdr[7]=write flag, hdr[6] ignored, hdr[5:0]=cmd; CNT 2 bytes; ADDR 4 bytes;
//   writes: then 4 data bytes per word. Words in burst = CNT+1.
//  States: IDLE->CNT_HI->CNT_LO->ADDR(4 bytes)->{WDATA | RD_ISSUE}.
//   Each transition that consumes a byte requires new_rx_data=1 that cycle;
//   otherwise the state holds. Header latched in IDLE -> m_write, m_cmd.
//  Write: WDATA collects 4 bytes; the cycle after the 4th byte m_new_cmd=1
//   for exactly 1 cycle with m_address/m_data valid. If words remain:
//   address+=1, count-=1, back to WDATA; else IDLE.
//  Read: cycle after 4th addr byte m_new_cmd=1 (1 cycle), m_write=0; go
//   RD_WAIT. On s_drdy latch s_data; s_drdy outside RD_WAIT is ignored.
//   TX: for bytes 3..0 (MSB first): wait tx_busy=0, drive tx_data + 1-cycle
//   new_tx_data, skip one cycle (busy latency), repeat. After 4th byte:
//   words remain -> address+=1, count-=1, new m_new_cmd, RD_WAIT; else IDLE.
//  rx bytes arriving during RD_WAIT/TX are discarded (half-duplex protocol).
//  m_write, m_cmd, m_address, m_data hold value between strobes (stable until
//   overwritten by the next packet's fields).
//  Address increments wrap modulo 2^32; CNT=0xFFFF gives 65536 words.
//  Reset mid-packet: immediate return to IDLE, outputs 0, partial packet lost.
//  m_new_cmd and new_tx_data never high simultaneously; never 2 cycles wide.
// TESTING
//  Reset: hold rst 6 cycles -> all outputs 0, no strobes while rst high.
//  Write: bytes C0,00,00,01,01,01,01,7F,7F,7F,7F -> one m_new_cmd pulse,
//   m_write=1, m_cmd=0, m_address=0x01010101, m_data=0x7F7F7F7F; back to IDLE.
//  Read: bytes 01,00,00,10,10,10,10 -> m_new_cmd pulse, m_write=0, m_cmd=1,
//   m_address=0x10101010; then s_data=0xAAAAAAAA, s_drdy 1 cycle, tx_busy=0 ->
//   four new_tx_data strobes, tx_data=AA each, then IDLE.
//  Burst write CNT=0x0001 addr 0x00000010 -> two strobes, addrs 0x10 then 0x11.
//  Back-pressure: tx_busy=1 during read reply -> no new_tx_data until busy drops.
//  Async reset asserted mid-ADDR -> IDLE; next full packet decodes correctly.

Source files
------------

// File: rtl/mmap_protocol_engine.sv
// Byte-stream to memory-map bridge: decodes UART command packets into
// single-cycle read/write requests and returns read data MSB-first as bytes.
module mmap_protocol_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        new_rx_data,
  output logic [7:0]  tx_data,
  output logic        new_tx_data,
  input  logic        tx_busy,
  output logic        m_new_cmd,
  output logic        m_write,
  output logic [5:0]  m_cmd,
  output logic [31:0] m_address,
  output logic [31:0] m_data,
  input  logic [31:0] s_data,
  input  logic        s_drdy
);

  typedef enum logic [3:0] {
    IDLE, CNT_HI, CNT_LO, ADDR, WDATA, WR_NEXT, RD_WAIT, TX, TX_SKIP
  } state_t;

  state_t      state_q;
  logic [15:0] count_q;
  logic [31:0] shift_q;
  logic [1:0]  bcnt_q;
  logic [7:0]  tx_data_q;
  logic        new_tx_q;
  logic        m_new_cmd_q;
  logic        m_write_q;
  logic [5:0]  m_cmd_q;
  logic [31:0] m_address_q;
  logic [31:0] m_data_q;

  assign tx_data     = tx_data_q;
  assign new_tx_data = new_tx_q;
  assign m_new_cmd   = m_new_cmd_q;
  assign m_write     = m_write_q;
  assign m_cmd       = m_cmd_q;
  assign m_address   = m_address_q;
  assign m_data      = m_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      shift_q     <= '0;
      bcnt_q      <= '0;
      tx_data_q   <= '0;
      new_tx_q    <= 1'b0;
      m_new_cmd_q <= 1'b0;
      m_write_q   <= 1'b0;
      m_cmd_q     <= '0;
      m_address_q <= '0;
      m_data_q    <= '0;
    end else begin
      // Strobes are single-cycle by construction: cleared every cycle unless re-armed.
      m_new_cmd_q <= 1'b0;
      new_tx_q    <= 1'b0;
      case (state_q)
        IDLE: if (new_rx_data) begin
          m_write_q <= rx_data[7];
          m_cmd_q   <= rx_data[5:0];
          state_q   <= CNT_HI;
        end
        CNT_HI: if (new_rx_data) begin
          count_q[15:8] <= rx_data;
          state_q       <= CNT_LO;
        end
        CNT_LO: if (new_rx_data) begin
          count_q[7:0] <= rx_data;
          bcnt_q       <= '0;
          state_q      <= ADDR;
        end
        ADDR: if (new_rx_data) begin
          shift_q <= {shift_q[23:0], rx_data};
          bcnt_q  <= bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            m_address_q <= {shift_q[23:0], rx_data};
            if (m_write_q) begin
              state_q <= WDATA;
            end else begin
              m_new_cmd_q <= 1'b1;
              state_q     <= RD_WAIT;
            end
          end
        end
        WDATA: if (new_rx_data) begin
          shift_q <= {shift_q[23:0], rx_data};
          bcnt_q  <= bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            m_data_q    <= {shift_q[23:0], rx_data};
            m_new_cmd_q <= 1'b1;
            state_q     <= WR_NEXT;
          end
        end
        // Address advances only after the strobe cycle so m_address stays valid with it.
        WR_NEXT: begin
          if (count_q != 16'd0) begin
            m_address_q <= m_address_q + 32'd1;
            count_q     <= count_q - 16'd1;
            state_q     <= WDATA;
          end else begin
            state_q <= IDLE;
          end
        end
        RD_WAIT: if (s_drdy) begin
          shift_q <= s_data;
          bcnt_q  <= '0;
          state_q <= TX;
        end
        TX: if (!tx_busy) begin
          tx_data_q <= shift_q[31:24];
          new_tx_q  <= 1'b1;
          shift_q   <= {shift_q[23:0], 8'h00};
          bcnt_q    <= bcnt_q + 2'd1;
          state_q   <= TX_SKIP;
        end
        // One idle cycle lets the transmitter raise tx_busy; bcnt wraps to 0 after byte 4.
        TX_SKIP: begin
          if (bcnt_q != 2'd0) begin
            state_q <= TX;
          end else if (count_q != 16'd0) begin
            m_address_q <= m_address_q + 32'd1;
            count_q     <= count_q - 16'd1;
            m_new_cmd_q <= 1'b1;
            state_q     <= RD_WAIT;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmap_protocol_engine.sv
// Directed bench: expected requests and tx bytes are queued as stimulus is
// driven, then popped and compared as the bridge emits strobes.
module tb_mmap_protocol_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        new_rx_data = 1'b0;
  logic [7:0]  tx_data;
  logic        new_tx_data;
  logic        tx_busy = 1'b0;
  logic        m_new_cmd;
  logic        m_write;
  logic [5:0]  m_cmd;
  logic [31:0] m_address;
  logic [31:0] m_data;
  logic [31:0] s_data = '0;
  logic        s_drdy = 1'b0;

  typedef struct packed {
    logic        wr;
    logic [5:0]  cmd;
    logic [31:0] addr;
    logic [31:0] data;
  } cmd_t;

  cmd_t       cmd_q[$];
  logic [7:0] tx_q[$];
  int checks   = 0;
  int failures = 0;
  int tx_seen  = 0;
  logic prev_cmd = 1'b0;
  logic prev_tx  = 1'b0;

  always #5 clk = ~clk;

  mmap_protocol_engine dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .new_rx_data(new_rx_data),
    .tx_data(tx_data), .new_tx_data(new_tx_data), .tx_busy(tx_busy),
    .m_new_cmd(m_new_cmd), .m_write(m_write), .m_cmd(m_cmd),
    .m_address(m_address), .m_data(m_data), .s_data(s_data), .s_drdy(s_drdy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  always @(negedge clk) begin
    if (m_new_cmd) begin
      check("cmd_tx_overlap", {31'd0, new_tx_data}, 32'd0);
      check("cmd_width", {31'd0, prev_cmd}, 32'd0);
      if (cmd_q.size() == 0) begin
        check("unexpected_cmd", 32'd1, 32'd0);
      end else begin
        cmd_t e;
        e = cmd_q.pop_front();
        check("m_write", {31'd0, m_write}, {31'd0, e.wr});
        check("m_cmd", {26'd0, m_cmd}, {26'd0, e.cmd});
        check("m_address", m_address, e.addr);
        if (e.wr) check("m_data", m_data, e.data);
      end
    end
    if (new_tx_data) begin
      tx_seen++;
      check("tx_width", {31'd0, prev_tx}, 32'd0);
      if (tx_q.size() == 0) begin
        check("unexpected_tx", 32'd1, 32'd0);
      end else begin
        logic [7:0] b;
        b = tx_q.pop_front();
        check("tx_data", {24'd0, tx_data}, {24'd0, b});
      end
    end
    prev_cmd = m_new_cmd;
    prev_tx  = new_tx_data;
  end

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    new_rx_data = 1'b1;
    @(posedge clk); #1;
    new_rx_data = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8]);
  endtask

  task automatic wait_cmds(input string tag);
    for (int i = 0; i < 300 && cmd_q.size() != 0; i++) @(posedge clk);
    #1;
    check(tag, cmd_q.size(), 32'd0);
  endtask

  task automatic wait_tx(input string tag);
    for (int i = 0; i < 300 && tx_q.size() != 0; i++) @(posedge clk);
    #1;
    check(tag, tx_q.size(), 32'd0);
  endtask

  task automatic push_tx(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) tx_q.push_back(w[8*i +: 8]);
  endtask

  task automatic pulse_drdy(input logic [31:0] d);
    s_data = d;
    s_drdy = 1'b1;
    @(posedge clk); #1;
    s_drdy = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    @(negedge clk);
    check(tag, {m_new_cmd, new_tx_data, m_write, tx_data, m_cmd}, 32'd0);
    check({tag, "_addr"}, m_address, 32'd0);
    check({tag, "_data"}, m_data, 32'd0);
  endtask

  initial begin
    // Power-on reset held for 6 cycles.
    for (int i = 0; i < 6; i++) check_reset_outputs("reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;

    // Single write.
    cmd_q.push_back('{1'b1, 6'd0, 32'h01010101, 32'h7F7F7F7F});
    send_byte(8'hC0); send_byte(8'h00); send_byte(8'h00);
    send_word(32'h01010101); send_word(32'h7F7F7F7F);
    wait_cmds("write_drain");
    check("write_hold_addr", m_address, 32'h01010101);

    // Single read, reply streamed back.
    cmd_q.push_back('{1'b0, 6'd1, 32'h10101010, 32'h0});
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
    send_word(32'h10101010);
    wait_cmds("read_cmd_drain");
    push_tx(32'hAAAAAAAA);
    pulse_drdy(32'hAAAAAAAA);
    wait_tx("read_tx_drain");
    repeat (5) @(posedge clk); #1;
    check("read_tx_count", tx_seen, 32'd4);

    // Burst write of two words.
    cmd_q.push_back('{1'b1, 6'd5, 32'h00000010, 32'h11223344});
    cmd_q.push_back('{1'b1, 6'd5, 32'h00000011, 32'h55667788});
    send_byte(8'h85); send_byte(8'h00); send_byte(8'h01);
    send_word(32'h00000010); send_word(32'h11223344); send_word(32'h55667788);
    wait_cmds("burst_drain");

    // Burst read with back-pressure and address wrap.
    cmd_q.push_back('{1'b0, 6'd2, 32'hFFFFFFFF, 32'h0});
    cmd_q.push_back('{1'b0, 6'd2, 32'h00000000, 32'h0});
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h01);
    send_word(32'hFFFFFFFF);
    for (int i = 0; i < 100 && cmd_q.size() != 1; i++) @(posedge clk);
    #1;
    check("rd_first_cmd", cmd_q.size(), 32'd1);
    tx_busy = 1'b1;
    pulse_drdy(32'h12345678);
    repeat (20) @(posedge clk); #1;
    check("busy_no_tx", tx_seen, 32'd4);
    push_tx(32'h12345678);
    tx_busy = 1'b0;
    wait_tx("bp_tx_drain");
    wait_cmds("wrap_cmd_drain");
    push_tx(32'hCAFEF00D);
    pulse_drdy(32'hCAFEF00D);
    wait_tx("wrap_tx_drain");
    repeat (5) @(posedge clk); #1;
    check("total_tx", tx_seen, 32'd12);
    // Stray s_drdy in IDLE must not produce bytes.
    pulse_drdy(32'h55555555);
    repeat (12) @(posedge clk); #1;
    check("stray_drdy", tx_seen, 32'd12);

    // Reset mid-address, then a clean packet.
    send_byte(8'h81); send_byte(8'h00); send_byte(8'h00);
    send_byte(8'hAB); send_byte(8'hCD);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) check_reset_outputs("mid_reset");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk); #1;
    cmd_q.push_back('{1'b1, 6'd3, 32'hDEADBEEF, 32'h01020304});
    send_byte(8'h83); send_byte(8'h00); send_byte(8'h00);
    send_word(32'hDEADBEEF); send_word(32'h01020304);
    wait_cmds("post_reset_drain");
    check("post_reset_hold_data", m_data, 32'h01020304);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
